// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the mem_ctrl memory sequencer
//
// Purpose: state enum, default widths and READ_WAIT bounds used by mem_ctrl and
//          mem_ctrl_rdbuf.
// Ports:   none (package).
package mem_ctrl_pkg;

   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_READ_WAIT = 1;

   // READ_WAIT bounds; the RD counter is sized for the upper bound.
   localparam int READ_WAIT_MIN = 1;
   localparam int READ_WAIT_MAX = 15;
   localparam int RD_CNT_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WSETUP,
      ST_WSTROBE,
      ST_WHOLD,
      ST_RESP
   } mem_ctrl_state_e;

   function automatic bit readWaitOk(input int rw);
      return (rw >= READ_WAIT_MIN) && (rw <= READ_WAIT_MAX);
   endfunction

endpackage

// File: rtl/mem_ctrl_rdbuf.sv
// rtl/mem_ctrl_rdbuf.sv - one-entry read buffer (valid, tag, data) for mem_ctrl
//
// Purpose: remembers the last word read from memory so a repeated load of the
//          same address can be answered without a memory cycle. Stores to the
//          tagged address update the buffered data (write-through).
// Ports:
//   clk, rstN             clock, asynchronous active-low reset (clears valid)
//   lookupAddr            address of the incoming load
//   hit, hitData          lookupAddr matches a valid tag, and the buffered word
//   fillEn/Addr/Data      load data captured from memory
//   wrEn/Addr/Data        store being strobed into memory
module mem_ctrl_rdbuf
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic [ADDR_W-1:0] lookupAddr,
   output logic              hit,
   output logic [DATA_W-1:0] hitData,
   input  logic              fillEn,
   input  logic [ADDR_W-1:0] fillAddr,
   input  logic [DATA_W-1:0] fillData,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData
);

   logic              bufValid;
   logic [ADDR_W-1:0] bufTag;
   logic [DATA_W-1:0] bufData;

   assign hit     = bufValid && (bufTag == lookupAddr);
   assign hitData = bufData;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         bufValid <= 1'b0;
         bufTag   <= '0;
         bufData  <= '0;
      end else if (fillEn) begin
         bufValid <= 1'b1;
         bufTag   <= fillAddr;
         bufData  <= fillData;
      end else if (wrEn && bufValid && (bufTag == wrAddr)) begin
         bufData  <= wrData;
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - load/store sequencer in front of the 16-bit memory block
//
// Purpose: accepts one request at a time, drives memory with setup/strobe/hold
//          timing for stores and a READ_WAIT-cycle read strobe for loads, and
//          returns a response over a valid/ready handshake.
// Build option: define MEM_CTRL_RDBUF_EN to add a one-entry read buffer.
// Ports:
//   clk, rstN                        clock, asynchronous active-low reset
//   reqValid/reqReady                request handshake
//   reqWrite, reqAddr, reqWData      request type (1=store), address, store data
//   rspValid/rspReady                response handshake
//   rspWrite, rspRData               echoed type, load data (0 for stores)
//   memAddr, memRe, memWe, memWBus   memory drive side
//   memRBus                          memory read data
//   busy                             high whenever the FSM is not idle
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int READ_WAIT = DEF_READ_WAIT
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqWrite,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [DATA_W-1:0] reqWData,
   output logic              rspValid,
   input  logic              rspReady,
   output logic              rspWrite,
   output logic [DATA_W-1:0] rspRData,
   output logic [ADDR_W-1:0] memAddr,
   output logic              memRe,
   output logic              memWe,
   output logic [DATA_W-1:0] memWBus,
   input  logic [DATA_W-1:0] memRBus,
   output logic              busy
);

   generate
      if (!readWaitOk(READ_WAIT)) begin : gBadReadWait
         $error("mem_ctrl: READ_WAIT out of range 1..15");
      end
   endgenerate

   mem_ctrl_state_e       state, stateNext;
   logic [RD_CNT_W-1:0]   rdCnt;
   logic                  rdLast;
   logic                  bufHit;
   logic [DATA_W-1:0]     bufData;

   assign rdLast = (rdCnt == RD_CNT_W'(READ_WAIT - 1));

`ifdef MEM_CTRL_RDBUF_EN
   // memAddr/memWBus already hold the latched request, so they double as the
   // fill and write-through address/data.
   mem_ctrl_rdbuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) uRdbuf (
      .clk        (clk),
      .rstN       (rstN),
      .lookupAddr (reqAddr),
      .hit        (bufHit),
      .hitData    (bufData),
      .fillEn     ((state == ST_RD) && rdLast),
      .fillAddr   (memAddr),
      .fillData   (memRBus),
      .wrEn       (state == ST_WSTROBE),
      .wrAddr     (memAddr),
      .wrData     (memWBus)
   );
`else
   assign bufHit  = 1'b0;
   assign bufData = '0;
`endif

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state <= ST_IDLE;
      else       state <= stateNext;
   end

   // Strobes are decoded straight from the state register so an asynchronous
   // reset drops them immediately.
   always_comb begin
      stateNext = state;
      reqReady  = 1'b0;
      rspValid  = 1'b0;
      memRe     = 1'b0;
      memWe     = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            reqReady = 1'b1;
            busy     = 1'b0;
            if (reqValid) begin
               if (reqWrite)    stateNext = ST_WSETUP;
               else if (bufHit) stateNext = ST_RESP;
               else             stateNext = ST_RD;
            end
         end
         ST_RD: begin
            memRe = 1'b1;
            if (rdLast) stateNext = ST_RESP;
         end
         ST_WSETUP:  stateNext = ST_WSTROBE;
         ST_WSTROBE: begin
            memWe     = 1'b1;
            stateNext = ST_WHOLD;
         end
         ST_WHOLD:   stateNext = ST_RESP;
         ST_RESP: begin
            rspValid = 1'b1;
            if (rspReady) stateNext = ST_IDLE;
         end
         default:    stateNext = ST_IDLE;
      endcase
   end

   // memAddr and memWBus act as the request latch: they are loaded only when a
   // memory cycle is about to start and otherwise keep their last value.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rdCnt    <= '0;
         rspWrite <= 1'b0;
         rspRData <= '0;
         memAddr  <= '0;
         memWBus  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (reqValid) begin
                  rspWrite <= reqWrite;
                  rdCnt    <= '0;
                  if (reqWrite) begin
                     memAddr <= reqAddr;
                     memWBus <= reqWData;
                  end else if (bufHit) begin
                     rspRData <= bufData;
                  end else begin
                     memAddr <= reqAddr;
                  end
               end
            end
            ST_RD: begin
               if (rdLast) rspRData <= memRBus;
               else        rdCnt    <= rdCnt + 1'b1;
            end
            ST_WHOLD: rspRData <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard testbench for mem_ctrl
module tb_mem_ctrl;

   localparam int RW = 1;
`ifdef MEM_CTRL_RDBUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstN;
   logic        reqValid, reqReady, reqWrite;
   logic [15:0] reqAddr, reqWData;
   logic        rspValid, rspReady, rspWrite;
   logic [15:0] rspRData;
   logic [15:0] memAddr, memWBus, memRBus;
   logic        memRe, memWe, busy;

   logic [15:0] mem [0:15];

   typedef struct packed {
      logic        w;
      logic [15:0] d;
   } exp_t;
   exp_t sbQ[$];

   int total = 0;
   int bad   = 0;
   int weCount = 0;

   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_W(16), .DATA_W(16), .READ_WAIT(RW)) dut (
      .clk      (clk),
      .rstN     (rstN),
      .reqValid (reqValid),
      .reqReady (reqReady),
      .reqWrite (reqWrite),
      .reqAddr  (reqAddr),
      .reqWData (reqWData),
      .rspValid (rspValid),
      .rspReady (rspReady),
      .rspWrite (rspWrite),
      .rspRData (rspRData),
      .memAddr  (memAddr),
      .memRe    (memRe),
      .memWe    (memWe),
      .memWBus  (memWBus),
      .memRBus  (memRBus),
      .busy     (busy)
   );

   // Behavioural memory: combinational read, write on the rising edge.
   assign memRBus = mem[memAddr[3:0]];
   always @(posedge clk) if (memWe) mem[memAddr[3:0]] <= memWBus;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per response handshake.
   always @(negedge clk) begin
      if (rstN) begin
         chk("re_we_excl", {31'd0, memRe & memWe}, 32'd0);
         if (memWe) weCount++;
         if (rspValid && rspReady) begin
            if (sbQ.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sbQ.pop_front();
               chk("sb_rsp_write", {31'd0, rspWrite}, {31'd0, e.w});
               chk("sb_rsp_data", {16'd0, rspRData}, {16'd0, e.d});
            end
         end
      end
   end

   task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input bit push, input logic [15:0] expD);
      int n;
      n = 0;
      while (!reqReady && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_ready_wait", {31'd0, reqReady}, 32'd1);
      if (push) sbQ.push_back('{w: w, d: expD});
      reqValid = 1'b1; reqWrite = w; reqAddr = a; reqWData = d;
      @(posedge clk); #1;
      reqValid = 1'b0;
   endtask

   task automatic store(input logic [15:0] a, input logic [15:0] d);
      int we0;
      we0 = weCount;
      issue(1'b1, a, d, 1'b1, 16'd0);
      @(negedge clk);
      chk("wsetup_we", {31'd0, memWe}, 32'd0);
      chk("wsetup_addr", {16'd0, memAddr}, {16'd0, a});
      chk("wsetup_data", {16'd0, memWBus}, {16'd0, d});
      chk("wsetup_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("wstrobe_we", {31'd0, memWe}, 32'd1);
      chk("wstrobe_addr", {16'd0, memAddr}, {16'd0, a});
      chk("wstrobe_data", {16'd0, memWBus}, {16'd0, d});
      @(negedge clk);
      chk("whold_we", {31'd0, memWe}, 32'd0);
      chk("whold_addr", {16'd0, memAddr}, {16'd0, a});
      chk("whold_data", {16'd0, memWBus}, {16'd0, d});
      chk("whold_rsp", {31'd0, rspValid}, 32'd0);
      @(negedge clk);
      chk("wresp_valid", {31'd0, rspValid}, 32'd1);
      @(negedge clk);
      chk("wdone_valid", {31'd0, rspValid}, 32'd0);
      chk("wdone_ready", {31'd0, reqReady}, 32'd1);
      chk("we_pulses", weCount - we0, 32'd1);
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] expD, input bit hit);
      issue(1'b0, a, 16'hA5A5, 1'b1, expD);
      if (hit) begin
         @(negedge clk);
         chk("hit_valid", {31'd0, rspValid}, 32'd1);
         chk("hit_re", {31'd0, memRe}, 32'd0);
      end else begin
         for (int k = 1; k <= RW; k++) begin
            @(negedge clk);
            chk("rd_re", {31'd0, memRe}, 32'd1);
            chk("rd_addr", {16'd0, memAddr}, {16'd0, a});
            chk("rd_valid", {31'd0, rspValid}, 32'd0);
         end
         @(negedge clk);
         chk("rresp_valid", {31'd0, rspValid}, 32'd1);
         chk("rresp_re", {31'd0, memRe}, 32'd0);
      end
      @(negedge clk);
      chk("rdone_valid", {31'd0, rspValid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int we0;
      int n;
      for (int i = 0; i < 16; i++) mem[i] = 16'd0;
      mem[5] = 16'h1111;
      rstN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0;
      reqAddr = 16'd0; reqWData = 16'd0; rspReady = 1'b1;

      // Reset values.
      repeat (2) @(negedge clk);
      chk("rst_reqReady", {31'd0, reqReady}, 32'd1);
      chk("rst_rspValid", {31'd0, rspValid}, 32'd0);
      chk("rst_rspWrite", {31'd0, rspWrite}, 32'd0);
      chk("rst_rspRData", {16'd0, rspRData}, 32'd0);
      chk("rst_memAddr", {16'd0, memAddr}, 32'd0);
      chk("rst_memWBus", {16'd0, memWBus}, 32'd0);
      chk("rst_strobes", {30'd0, memRe, memWe}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rstN = 1'b1;
      @(negedge clk);
      chk("rel_reqReady", {31'd0, reqReady}, 32'd1);
      chk("rel_busy", {31'd0, busy}, 32'd0);

      // Store then load back.
      store(16'd1, 16'd567);
      load(16'd1, 16'd567, 1'b0);

      // Response back-pressure; request pulses in the window must be ignored.
      @(posedge clk); #1;
      rspReady = 1'b0;
      issue(1'b0, 16'd1, 16'd0, 1'b1, 16'd567);
      n = 0;
      while (!rspValid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_rsp_seen", {31'd0, rspValid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         reqValid = (i != 1); reqWrite = 1'b1; reqAddr = 16'd1; reqWData = 16'd999;
         @(negedge clk);
         chk("stall_valid", {31'd0, rspValid}, 32'd1);
         chk("stall_data", {16'd0, rspRData}, 32'd567);
         chk("stall_reqReady", {31'd0, reqReady}, 32'd0);
      end
      @(posedge clk); #1;
      reqValid = 1'b0; rspReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("stall_done_valid", {31'd0, rspValid}, 32'd0);
      chk("stall_done_ready", {31'd0, reqReady}, 32'd1);

      // Reset during WSETUP of a store to addr 5.
      we0 = weCount;
      issue(1'b1, 16'd5, 16'hBEEF, 1'b0, 16'd0);
      @(negedge clk);
      chk("abort_wsetup_we", {31'd0, memWe}, 32'd0);
      #2 rstN = 1'b0;
      #1;
      chk("abort_we", {31'd0, memWe}, 32'd0);
      chk("abort_rsp", {31'd0, rspValid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_no_we", weCount - we0, 32'd0);
      chk("abort_no_rsp", sbQ.size(), 32'd0);
      load(16'd5, 16'h1111, 1'b0);

      // All-ones data and address 0.
      store(16'd2, 16'hFFFF);
      load(16'd2, 16'hFFFF, 1'b0);
      load(16'd0, 16'h0000, 1'b0);

      // Repeat load, then store and reload (buffer hits when compiled in).
      load(16'd1, 16'd567, 1'b0);
      load(16'd1, 16'd567, BUF);
      store(16'd1, 16'd42);
      load(16'd1, 16'd42, BUF);

      @(negedge clk);
      chk("sb_empty", sbQ.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
